// File: rtl/field_shader_if.sv
// Pixel-stream bundle between the field evaluator / timing generator and the shader.
// master drives the raw timing and field sum; slave (the shader) returns the registered pixel.
interface field_shader_if;
  logic       display_in;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [8:0] field;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       display_out;
  logic       h_sync_out;
  logic       v_sync_out;
  logic [7:0] frame_count;

  modport master (
    output display_in, h_sync_in, v_sync_in, field,
    input  r, g, b, display_out, h_sync_out, v_sync_out, frame_count
  );

  modport slave (
    input  display_in, h_sync_in, v_sync_in, field,
    output r, g, b, display_out, h_sync_out, v_sync_out, frame_count
  );
endinterface

// File: rtl/field_shader.sv
// Metaball pixel output stage: threshold-band colouring with a frame-rotated palette,
// sync/blanking delayed in lockstep with the colour pipeline.
module field_shader #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned THRESHOLD  = 10,
  parameter int unsigned BAND_SHIFT = 3,
  parameter int unsigned CYCLE_DIV  = 4
) (
  input  logic          clk_50mhz,
  input  logic          reset,
  field_shader_if.slave px
);

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       display;
    logic       h_sync;
    logic       v_sync;
  } stage_t;

  localparam stage_t     IDLE     = '{r: 2'd0, g: 2'd0, b: 2'd0,
                                      display: 1'b0, h_sync: 1'b1, v_sync: 1'b1};
  localparam logic [8:0] THR      = 9'(THRESHOLD);
  localparam logic [7:0] DIV_LAST = 8'(CYCLE_DIV - 1);

  logic [1:0] phase;
  logic [7:0] div;
  logic [7:0] frame_count;
  logic       v_sync_prev;
  logic       fe;

  logic [8:0] excess;
  logic [8:0] shifted;
  logic [1:0] band;
  logic [1:0] idx;
  stage_t     s1;
  stage_t     pipe [LATENCY];

  always_comb begin
    fe      = v_sync_prev & ~px.v_sync_in;
    excess  = px.field - THR - 9'd1;
    shifted = excess >> BAND_SHIFT;
    band    = (shifted > 9'd3) ? 2'd3 : shifted[1:0];
    idx     = band + phase;

    s1         = IDLE;
    s1.display = px.display_in;
    s1.h_sync  = px.h_sync_in;
    s1.v_sync  = px.v_sync_in;
    if (px.display_in && (px.field > THR)) begin
      case (idx)
        2'd0:    begin s1.r = 2'd3; s1.g = 2'd3; s1.b = 2'd3; end
        2'd1:    begin s1.r = 2'd3; s1.g = 2'd2; s1.b = 2'd0; end
        2'd2:    begin s1.r = 2'd3; s1.g = 2'd0; s1.b = 2'd1; end
        default: begin s1.r = 2'd0; s1.g = 2'd1; s1.b = 2'd3; end
      endcase
    end
  end

  // Colour and timing travel as one word so no skew can develop between them.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe[i] <= IDLE;
    end else begin
      pipe[0] <= s1;
      for (int unsigned i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // phase updates on the fe edge, so the fe-cycle pixel still sees the old value.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      phase       <= '0;
      div         <= '0;
      frame_count <= '0;
      v_sync_prev <= 1'b1;
    end else begin
      v_sync_prev <= px.v_sync_in;
      if (fe) begin
        frame_count <= frame_count + 8'd1;
        if (div == DIV_LAST) begin
          div   <= '0;
          phase <= phase + 2'd1;
        end else begin
          div <= div + 8'd1;
        end
      end
    end
  end

  assign px.r           = pipe[LATENCY-1].r;
  assign px.g           = pipe[LATENCY-1].g;
  assign px.b           = pipe[LATENCY-1].b;
  assign px.display_out = pipe[LATENCY-1].display;
  assign px.h_sync_out  = pipe[LATENCY-1].h_sync;
  assign px.v_sync_out  = pipe[LATENCY-1].v_sync;
  assign px.frame_count = frame_count;

endmodule

// File: tb/tb_field_shader.sv
// Scoreboard bench for field_shader: directed stimulus queues hand-computed expectations
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_field_shader;
  localparam int unsigned LAT = 2;

  localparam logic [5:0] C_BLK = 6'b00_00_00;
  localparam logic [5:0] C_WHT = 6'b11_11_11;
  localparam logic [5:0] C_ORG = 6'b11_10_00;
  localparam logic [5:0] C_MAG = 6'b11_00_01;
  localparam logic [5:0] C_BLU = 6'b00_01_11;

  logic clk_50mhz = 1'b0;
  logic reset;
  always #10 clk_50mhz = ~clk_50mhz;

  field_shader_if bus ();

  field_shader #(
    .LATENCY   (LAT),
    .THRESHOLD (10),
    .BAND_SHIFT(3),
    .CYCLE_DIV (4)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .px       (bus)
  );

  typedef struct {
    int         cyc;
    bit         chk_pix;
    bit         chk_fc;
    logic [8:0] pix;
    logic [7:0] fc;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [8:0] act;
  logic [7:0] fc_model = 8'd0;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  always @(negedge clk_50mhz) begin
    act = {bus.r, bus.g, bus.b, bus.display_out, bus.h_sync_out, bus.v_sync_out};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_cmp++;
        if (exp_q[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: due at cycle %0d, not checked until %0d", exp_q[i].name, exp_q[i].cyc, cyc);
        end else if ((exp_q[i].chk_pix && act !== exp_q[i].pix) ||
                     (exp_q[i].chk_fc && bus.frame_count !== exp_q[i].fc)) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got rgb_d_hs_vs=%b fc=%0d, expected %b fc=%0d (pix %0b fc %0b checked)",
                   exp_q[i].name, cyc, act, bus.frame_count, exp_q[i].pix, exp_q[i].fc,
                   exp_q[i].chk_pix, exp_q[i].chk_fc);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic drive(input logic d, input logic hs, input logic vs, input logic [8:0] f);
    bus.display_in = d;
    bus.h_sync_in  = hs;
    bus.v_sync_in  = vs;
    bus.field      = f;
  endtask

  task automatic push(input string name, input int off, input logic [5:0] rgb,
                      input logic d, input logic hs, input logic vs);
    exp_t e;
    e.cyc = cyc + off; e.chk_pix = 1'b1; e.chk_fc = 1'b0;
    e.pix = {rgb, d, hs, vs}; e.fc = 8'd0; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_fc(input string name, input int off, input logic [7:0] fc);
    exp_t e;
    e.cyc = cyc + off; e.chk_pix = 1'b0; e.chk_fc = 1'b1;
    e.pix = '0; e.fc = fc; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive_random();
    bus.display_in = 1'($urandom_range(0, 1));
    bus.h_sync_in  = 1'($urandom_range(0, 1));
    bus.v_sync_in  = 1'($urandom_range(0, 1));
    bus.field      = 9'($urandom_range(0, 511));
  endtask

  // One v_sync falling edge, low for low_cyc cycles then high for high_cyc cycles.
  task automatic frame_edge(input int low_cyc, input int high_cyc);
    step();
    drive(1'b0, 1'b1, 1'b0, 9'd0);
    fc_model = fc_model + 8'd1;
    push_fc("frame_count_edge", 1, fc_model);
    for (int i = 1; i < low_cyc; i++) begin step(); drive(1'b0, 1'b1, 1'b0, 9'd0); end
    for (int i = 0; i < high_cyc; i++) begin step(); drive(1'b0, 1'b1, 1'b1, 9'd0); end
    push_fc("frame_count_hold", 0, fc_model);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  logic [8:0] sweep_f [8];
  logic [5:0] sweep_c [8];

  initial begin
    sweep_f = '{9'd10, 9'd11, 9'd18, 9'd19, 9'd27, 9'd34, 9'd35, 9'd511};
    sweep_c = '{C_BLK, C_WHT, C_WHT, C_ORG, C_MAG, C_MAG, C_BLU, C_BLU};

    // Reset held 3 cycles with random inputs, then idle through the first LAT-1 cycles.
    reset = 1'b1;
    drive_random();
    for (int i = 0; i < 3; i++) begin
      step();
      push("reset_idle", 0, C_BLK, 1'b0, 1'b1, 1'b1);
      push_fc("reset_fc", 0, 8'd0);
      drive_random();
    end
    reset = 1'b0;
    drive_random();
    bus.v_sync_in = 1'b1;
    for (int j = 1; j < int'(LAT); j++) push("release_idle", j, C_BLK, 1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= int'(LAT); j++) push_fc("release_fc", j, 8'd0);

    // Single bright pixel surrounded by field=0.
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 1'b1, 1'b1, (i == 1) ? 9'd12 : 9'd0);
      push("single_pixel", LAT, (i == 1) ? C_WHT : C_BLK, 1'b1, 1'b1, 1'b1);
    end

    // 120-cycle h_sync pulse with one idle cycle either side.
    for (int i = 0; i < 122; i++) begin
      step();
      drive(1'b0, (i >= 1 && i <= 120) ? 1'b0 : 1'b1, 1'b1, 9'd0);
      push("h_sync_pulse", LAT, C_BLK, 1'b0, (i >= 1 && i <= 120) ? 1'b0 : 1'b1, 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      step();
      drive(1'b1, 1'b1, 1'b1, sweep_f[i]);
      push("band_sweep", LAT, sweep_c[i], 1'b1, 1'b1, 1'b1);
    end

    step();
    drive(1'b0, 1'b1, 1'b1, 9'd200);
    push("blanked", LAT, C_BLK, 1'b0, 1'b1, 1'b1);

    // Three edges with 6-line (6x40 cycle) lows, then the fourth edge carries pixels.
    for (int k = 0; k < 3; k++) frame_edge(240, 40);
    step();
    drive(1'b1, 1'b1, 1'b0, 9'd12);
    fc_model = fc_model + 8'd1;
    push_fc("frame_count_edge4", 1, fc_model);
    push("fe_cycle_old_phase", LAT, C_WHT, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 9'd12);
    push("after_fe_new_phase", LAT, C_ORG, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i < 240; i++) begin step(); drive(1'b0, 1'b1, 1'b0, 9'd0); end
    push_fc("long_low_once", 0, 8'd4);
    step();
    drive(1'b1, 1'b1, 1'b1, 9'd12);
    push("phase1_colour", LAT, C_ORG, 1'b1, 1'b1, 1'b1);

    // Up to 256 edges total: frame_count wraps to 0 and phase returns to 0.
    for (int k = 4; k < 256; k++) frame_edge(2, 2);
    push_fc("frame_count_wrap", 0, 8'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 9'd12);
    push("phase_wrapped_0", LAT, C_WHT, 1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 4; k++) frame_edge(2, 2);
    step();
    drive(1'b1, 1'b1, 1'b1, 9'd12);
    push("phase1_again", LAT, C_ORG, 1'b1, 1'b1, 1'b1);

    // Mid-line reset coinciding with a v_sync fall: pipeline flushed, frame not counted.
    step();
    drive(1'b1, 1'b1, 1'b1, 9'd12);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 9'd12);
    push("midline_reset_flush", 1, C_BLK, 1'b0, 1'b1, 1'b1);
    push_fc("midline_reset_fc", 1, 8'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 9'd12);
    push("post_reset_idle", 1, C_BLK, 1'b0, 1'b1, 1'b1);
    push("post_reset_phase0", LAT, C_WHT, 1'b1, 1'b1, 1'b1);
    push_fc("post_reset_fc", LAT, 8'd0);

    step();
    drive(1'b0, 1'b1, 1'b1, 9'd0);
    for (int i = 0; i < int'(LAT) + 4 && exp_q.size() > 0; i++) step();
    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: due at cycle %0d, never checked", exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/field_shader.md
Name: field_shader

Overview:
- Pixel output stage directly downstream of the metaball field evaluation. It consumes the per-pixel field sum plus raw VGA timing and produces registered 2-bit-per-channel RGB.
- Colour comes from threshold bands and a palette phase that rotates once per N frames.
- Sync and blanking are delayed to match the colour pipeline exactly. All logic runs on clk_50mhz; v_sync is sampled, never used as a clock.

Parameters:
- LATENCY, 2, input-to-output delay in cycles for all outputs; legal 1..4
- THRESHOLD, 10, field value at or below which a pixel is black
- BAND_SHIFT, 3, log2 of band width in field units
- CYCLE_DIV, 4, frames per palette phase step; legal 1..255

Ports:
- clk_50mhz  in  1  pixel clock
- reset  in  1  synchronous, active-high
- display_in  in  1  visible-area flag from timing generator
- h_sync_in  in  1  horizontal sync, active-low, idle high
- v_sync_in  in  1  vertical sync, active-low, idle high
- field  in  9  sum of ball contributions, unsigned 0..511
- r  out  2  red
- g  out  2  green
- b  out  2  blue
- display_out  out  1  display_in delayed LATENCY cycles
- h_sync_out  out  1  h_sync_in delayed LATENCY cycles
- v_sync_out  out  1  v_sync_in delayed LATENCY cycles
- frame_count  out  8  count of v_sync falling edges since reset, wraps

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk_50mhz.
- Reset values: r=g=b=0, display_out=0, h_sync_out=1, v_sync_out=1, frame_count=0. Internal phase=0, div=0, v_sync_prev=1.
  - Every delay-line stage is loaded with these idle values, so no glitch appears during the first LATENCY cycles after release.
- Stage 1 (computed from inputs at cycle n):
  - If field <= THRESHOLD or display_in=0, colour is (0,0,0).
  - Otherwise band = min(3, (field - THRESHOLD - 1) >> BAND_SHIFT). The subtraction is done in 9 bits and cannot underflow in this branch.
  - idx = (band + phase) mod 4, a 2-bit wrapping add.
  - Palette (r,g,b): idx0=(3,3,3), idx1=(3,2,0), idx2=(3,0,1), idx3=(0,1,3).
- Stages 2..LATENCY are pure delays. Colour, display, h_sync and v_sync all exit together at cycle n+LATENCY; no skew between them is allowed.
- Frame edge:
  - fe = v_sync_prev & ~v_sync_in; v_sync_prev is registered every cycle.
  - On fe, frame_count increments (255 to 0 wraps).
  - On fe, if div = CYCLE_DIV-1 then div=0 and phase increments (2-bit wrap); otherwise div increments.
- Phase timing: a new phase value applies to pixels entering stage 1 on the cycle after fe. The pixel arriving on the fe cycle still uses the old phase.
- A low v_sync lasting many lines counts exactly once. A glitch-free level change is assumed by the timing generator; no debounce.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and in-flight pipeline contents are discarded.
- Simultaneous reset and fe: reset wins and the frame is not counted.

Test Plan:
- Reset with random inputs held 3 cycles -> r=g=b=0, display_out=0, h_sync_out=v_sync_out=1, frame_count=0 throughout, including the LATENCY cycles after release.
- LATENCY=2, display_in=1, field=12 for one cycle at n, else 0 -> rgb=(3,3,3) at n+2 only. An h_sync_in low pulse of 120 cycles starting at m -> h_sync_out low for cycles m+2..m+121.
- Phase 0, display_in=1, field sweep 10,11,18,19,27,34,35,511 -> outputs in order:
  - (0,0,0), (3,3,3), (3,3,3), (3,2,0), (3,0,1), (3,0,1), (0,1,3), (0,1,3).
- display_in=0 with field=200 -> rgb=(0,0,0), display_out=0 after LATENCY cycles.
- CYCLE_DIV=4, four v_sync_in falling edges each followed by 6-line-long low -> frame_count=4, phase=1, so field=12 gives (3,2,0). After 256 total edges frame_count=0.
- After phase=1, assert reset one cycle mid-line -> next cycle frame_count=0, pipeline flushed; field=12 then yields (3,3,3) after LATENCY.
